// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clkgen_pkg;

  // Lock-gating FSM: wait for PLL lock, let it settle, then run the accumulators.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } clkgen_state_t;

  // Settle counter width able to hold LOCK_SETTLE itself.
  function automatic int settle_width(input int lock_settle);
    return $clog2(lock_settle + 1);
  endfunction

endpackage

// File: rtl/clkgen_fracstrb_ch.sv
// One phase-accumulator channel: the carry out of acc + inc becomes a registered strobe.
module fracstrb_ch #(
  parameter int ACC_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_strobe
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, i_inc};

  // Accumulate while enabled; a disable or phase reset zeroes the phase and suppresses the carry.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would chain flops within one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc      <= '0;
      o_strobe <= 1'b0;
    end else if (!i_en || i_clr) begin
      acc      <= '0;
      o_strobe <= 1'b0;
    end else begin
      acc      <= sum[ACC_W-1:0];
      o_strobe <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/clkgen_fracstrb.sv
// Multi-channel fractional clock-enable generator gated by a synchronised, settled PLL lock.
module clkgen_fracstrb
  import clkgen_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          ACC_W       = 24,
  parameter int unsigned INC_RESET   = 0,
  parameter int          LOCK_SETTLE = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_locked,
  input  logic                           i_cfg_valid,
  output logic                           o_cfg_ready,
  input  logic [($clog2(N_CH) | 1)-1:0]  i_cfg_ch,
  input  logic [ACC_W-1:0]               i_cfg_inc,
  input  logic                           i_cfg_phaserst,
  output logic                           o_cfg_err,
  output logic                           o_run,
  output logic [N_CH-1:0]                o_strobe
);

  localparam int CH_W     = $clog2(N_CH) | 1;
  localparam int SETTLE_W = settle_width(LOCK_SETTLE);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);
  localparam logic [CH_W:0]       N_CH_L      = (CH_W + 1)'(N_CH);
  localparam logic [ACC_W-1:0]    INC_INIT    = ACC_W'(INC_RESET);

  logic                lk_meta;
  logic                lk_s;
  clkgen_state_t       state;
  clkgen_state_t       state_nxt;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] cnt_nxt;
  logic                run_en;
  logic                ch_ok;
  logic                phase_clr;
  logic [ACC_W-1:0]    inc [N_CH];

  // The config port never back-pressures.
  assign o_cfg_ready = 1'b1;

  assign ch_ok     = ({1'b0, i_cfg_ch} < N_CH_L);
  assign phase_clr = i_cfg_valid && i_cfg_phaserst;

  // Accumulate only on edges where the FSM stays in RUN, so any exit zeroes phase and strobes at once.
  assign run_en = (state == RUN) && lk_s;

  // Two-flop synchroniser bringing the asynchronous PLL lock into the fabric domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= i_locked;
      lk_s    <= lk_meta;
    end
  end

  // Next-state logic: lock must be stable for LOCK_SETTLE cycles before running; any drop restarts.
  // NOTE: defaults at the top of always_comb give every path an assignment, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + SETTLE_W'(1);
        end
      end
      RUN: begin
        if (!lk_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // FSM state, settle counter and registered run flag (high from the edge that enters RUN).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      o_run <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      o_run <= (state_nxt == RUN);
    end
  end

  // Increment register file; written in any state and kept across lock loss.
  // NOTE: this small register file is reset explicitly because its reset value is part of the interface; large RAMs would not be.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_CH; k++) inc[k] <= INC_INIT;
    end else if (i_cfg_valid) begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_cfg_ch == CH_W'(k)) inc[k] <= i_cfg_inc;
      end
    end
  end

  // One-cycle error pulse for an accepted write to a channel that does not exist.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_cfg_err <= 1'b0;
    else       o_cfg_err <= i_cfg_valid && !ch_ok;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fracstrb_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (run_en),
      .i_clr    (phase_clr),
      .i_inc    (inc[g]),
      .o_strobe (o_strobe[g])
    );
  end

endmodule

// File: tb/tb_clkgen_fracstrb.sv
// Directed bench for clkgen_fracstrb: expected strobe cycles are queued per channel and a monitor checks each pulse.
module tb_clkgen_fracstrb;

  localparam int N_CH        = 4;
  localparam int ACC_W       = 8;
  localparam int LOCK_SETTLE = 16;
  localparam int CH_W        = $clog2(N_CH) | 1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_locked;
  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [CH_W-1:0]   i_cfg_ch;
  logic [ACC_W-1:0]  i_cfg_inc;
  logic              i_cfg_phaserst;
  logic              o_cfg_err;
  logic              o_run;
  logic [N_CH-1:0]   o_strobe;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int exp_q [N_CH][$];
  int win_cnt   [N_CH];
  int win_first [N_CH];
  int cur_inc   [N_CH];
  bit win_on = 1'b0;
  int win_lo = 0;
  int win_hi = 0;

  clkgen_fracstrb #(
    .N_CH        (N_CH),
    .ACC_W       (ACC_W),
    .INC_RESET   (0),
    .LOCK_SETTLE (LOCK_SETTLE)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_locked       (i_locked),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_ch       (i_cfg_ch),
    .i_cfg_inc      (i_cfg_inc),
    .i_cfg_phaserst (i_cfg_phaserst),
    .o_cfg_err      (o_cfg_err),
    .o_run          (o_run),
    .o_strobe       (o_strobe)
  );

  always #5 i_clk = ~i_clk;

  // Cycle index: the interval after the n-th rising edge is cycle n.
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cfg_write(input int ch, input int inc, input bit prst);
    i_cfg_valid    = 1'b1;
    i_cfg_ch       = CH_W'(ch);
    i_cfg_inc      = ACC_W'(inc);
    i_cfg_phaserst = prst;
    tick();
    i_cfg_valid    = 1'b0;
    i_cfg_phaserst = 1'b0;
    if (ch < N_CH) cur_inc[ch] = inc;
  endtask

  // Phase is zero after edge e; add j lands at edge e+j and strobes in cycle e+j when it carries.
  task automatic open_window(input int e, input int len);
    for (int k = 0; k < N_CH; k++) begin
      win_cnt[k]   = 0;
      win_first[k] = -1;
      exp_q[k].delete();
      for (int j = 1; j <= len; j++) begin
        if (((j * cur_inc[k]) >> ACC_W) != (((j - 1) * cur_inc[k]) >> ACC_W))
          exp_q[k].push_back(e + j);
      end
    end
    win_lo = e + 1;
    win_hi = e + len;
    win_on = 1'b1;
  endtask

  task automatic close_window(input string tag, input int c0, input int c1, input int c2, input int c3);
    int want [N_CH];
    want = '{c0, c1, c2, c3};
    wait_until(win_hi + 1);
    win_on = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      check($sformatf("%s_count_ch%0d", tag, k), win_cnt[k], want[k]);
      check($sformatf("%s_missing_ch%0d", tag, k), exp_q[k].size(), 0);
    end
  endtask

  // Monitor: every strobe inside an open window must match the next queued cycle for its channel.
  always @(negedge i_clk) begin
    if (win_on && cyc >= win_lo && cyc <= win_hi) begin
      for (int k = 0; k < N_CH; k++) begin
        if (o_strobe[k] === 1'b1) begin
          win_cnt[k]++;
          if (win_first[k] < 0) win_first[k] = cyc;
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_extra_ch%0d: got strobe at cycle %0d, expected none", k, cyc);
          end else begin
            check($sformatf("strobe_time_ch%0d", k), cyc, exp_q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, e, l, r, q;
    i_rst          = 1'b1;
    i_locked       = 1'b0;
    i_cfg_valid    = 1'b0;
    i_cfg_ch       = '0;
    i_cfg_inc      = '0;
    i_cfg_phaserst = 1'b0;
    for (int k = 0; k < N_CH; k++) cur_inc[k] = 0;

    // Reset state.
    repeat (3) tick();
    check("rst_run", o_run, 0);
    check("rst_strobe", o_strobe, 0);
    check("rst_err", o_cfg_err, 0);
    check("rst_ready", o_cfg_ready, 1);
    i_rst = 1'b0;
    repeat (3) tick();
    check("nolock_run", o_run, 0);

    // Test 1: lock rises at t0, one-cycle dropout at t0+10 restarts the settle (run at t0+30, not t0+19).
    t0 = cyc;
    i_locked = 1'b1;
    wait_until(t0 + 10);
    i_locked = 1'b0;
    tick();
    i_locked = 1'b1;
    wait_until(t0 + 19);
    check("glitch_run_19", o_run, 0);
    wait_until(t0 + 29);
    check("glitch_run_29", o_run, 0);
    wait_until(t0 + 30);
    check("glitch_run_30", o_run, 1);
    check("run_idle_strobe", o_strobe, 0);

    // Test 2: ch0=64, ch1=128, phases aligned by the second write.
    cfg_write(0, 64, 1'b0);
    cfg_write(1, 128, 1'b1);
    e = cyc;
    open_window(e, 256);
    close_window("t2", 64, 128, 0, 0);

    // Test 3: ch2=85 and the max increment 255 on ch3.
    cfg_write(2, 85, 1'b0);
    cfg_write(3, 255, 1'b1);
    e = cyc;
    open_window(e, 256);
    close_window("t3", 64, 128, 85, 255);

    // Test 4: ch0=32 with phase reset while running.
    cfg_write(0, 32, 1'b1);
    e = cyc;
    open_window(e, 64);
    close_window("t4", 8, 32, 21, 63);
    check("t4_first_ch0", win_first[0], e + 8);
    check("t4_first_ch1", win_first[1], e + 2);

    // Test 5: out-of-range write pulses the error for one cycle only.
    check("err_idle", o_cfg_err, 0);
    cfg_write(5, 99, 1'b0);
    check("err_pulse", o_cfg_err, 1);
    tick();
    check("err_clear", o_cfg_err, 0);

    // Test 5: lock loss in RUN stops output within 3 cycles.
    l = cyc;
    i_locked = 1'b0;
    wait_until(l + 2);
    check("drop_run_l2", o_run, 1);
    wait_until(l + 3);
    check("drop_run_l3", o_run, 0);
    check("drop_strobe_l3", o_strobe, 0);
    wait_until(l + 4);
    check("drop_strobe_l4", o_strobe, 0);
    wait_until(l + 8);

    // Relock: run 19 cycles after the rise, increments retained, phase restarts from zero.
    r = cyc;
    i_locked = 1'b1;
    wait_until(r + 18);
    check("relock_run_18", o_run, 0);
    wait_until(r + 19);
    check("relock_run_19", o_run, 1);
    open_window(r + 19, 64);
    close_window("t5", 8, 32, 21, 63);

    // Test 6: asynchronous reset mid-RUN with ch3 strobing nearly every cycle.
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_run", o_run, 0);
    check("arst_strobe", o_strobe, 0);
    check("arst_err", o_cfg_err, 0);
    check("arst_ready", o_cfg_ready, 1);
    tick();
    i_rst = 1'b0;
    q = cyc;
    for (int k = 0; k < N_CH; k++) cur_inc[k] = 0;
    wait_until(q + 18);
    check("rst_relock_run_18", o_run, 0);
    wait_until(q + 19);
    check("rst_relock_run_19", o_run, 1);
    open_window(q + 19, 256);
    close_window("t6", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
